// File: rtl/fetch.sv
// Instruction-fetch stage with IF/ID register and one-entry skid buffer.
// Absorbs memory waits, decode stalls, redirects and sticky halt.
module fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  input  logic        halt,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic [15:0] instr,
  output logic [15:0] PCplus2,
  output logic        valid,
  output logic        err
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DRAIN,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } slot_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] req_addr;
  slot_t       skid;
  logic        skid_v;
  logic        halt_pend;

  logic [15:0] pc_inc;
  logic [15:0] tgt;
  logic        issue;
  logic        busy;

  assign pc_inc = pc + 16'd2;
  assign tgt    = {redirectPC[15:1], 1'b0};
  assign busy   = (state == S_WAIT) || (state == S_DRAIN);

  // New requests only from RUN; redirect/halt suppress them.
  assign issue = (state == S_RUN) && !stall && !skid_v
              && !halt && !redirect;

  assign imemRd   = !rst && (issue || busy);
  assign imemAddr = (state == S_RUN) ? pc : req_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      skid      <= '0;
      skid_v    <= 1'b0;
      halt_pend <= 1'b0;
      instr     <= NOP_INSTR;
      PCplus2   <= 16'h0000;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == S_HALTED) begin
        if (!stall) begin
          instr <= NOP_INSTR;
          valid <= 1'b0;
        end
      end else if (redirect) begin
        pc        <= tgt;
        err       <= redirectPC[0];
        instr     <= NOP_INSTR;
        valid     <= 1'b0;
        skid_v    <= 1'b0;
        halt_pend <= 1'b0;
        state     <= (busy && !imemDone) ? S_DRAIN : S_RUN;
      end else if (halt) begin
        skid_v <= 1'b0;
        if (!stall) begin
          instr <= NOP_INSTR;
          valid <= 1'b0;
        end
        if (busy && !imemDone) begin
          halt_pend <= 1'b1;
          state     <= S_DRAIN;
        end else begin
          state <= S_HALTED;
        end
      end else begin
        unique case (state)
          S_RUN: begin
            if (!stall && skid_v) begin
              instr   <= skid.instr;
              PCplus2 <= skid.pc2;
              valid   <= 1'b1;
              skid_v  <= 1'b0;
            end else if (!stall) begin
              req_addr <= pc;
              if (imemDone) begin
                instr   <= imemData;
                PCplus2 <= pc_inc;
                valid   <= 1'b1;
                pc      <= pc_inc;
              end else begin
                instr <= NOP_INSTR;
                valid <= 1'b0;
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (imemDone) begin
              pc    <= pc_inc;
              state <= S_RUN;
              if (stall) begin
                skid   <= '{instr: imemData, pc2: pc_inc};
                skid_v <= 1'b1;
              end else begin
                instr   <= imemData;
                PCplus2 <= pc_inc;
                valid   <= 1'b1;
              end
            end else if (!stall) begin
              instr <= NOP_INSTR;
              valid <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (!stall) begin
              instr <= NOP_INSTR;
              valid <= 1'b0;
            end
            if (imemDone) begin
              state <= halt_pend ? S_HALTED : S_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, corner sequences and a
// randomized run checked against an instruction-stream scoreboard.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        halt;
  logic        imemRd;
  logic [15:0] imemAddr;
  logic [15:0] imemData;
  logic        imemDone;
  logic [15:0] instr;
  logic [15:0] PCplus2;
  logic        valid;
  logic        err;

  localparam logic [15:0] NOP = 16'h0800;

  int tests = 0;
  int fails = 0;

  fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirectPC(redirectPC),
    .halt(halt), .imemRd(imemRd), .imemAddr(imemAddr),
    .imemData(imemData), .imemDone(imemDone),
    .instr(instr), .PCplus2(PCplus2),
    .valid(valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  assign imemData = mem(imemAddr);

  typedef struct {
    logic        s, r, h, d;
    logic [15:0] rp;
    logic        ck_rd, e_rd;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_i, e_p;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
    input logic s, r, h, d, input logic [15:0] rp,
    input logic ckrd, erd, input logic [15:0] ea,
    input logic ev, input logic [15:0] ei, ep, input logic ee);
    vec_t v;
    v.s = s; v.r = r; v.h = h; v.d = d; v.rp = rp;
    v.ck_rd = ckrd; v.e_rd = erd; v.e_addr = ea;
    v.e_v = ev; v.e_i = ei; v.e_p = ep; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic s, r, input logic [15:0] rp,
                     input logic h, d);
    @(negedge clk);
    rst = 1'b0; stall = s; redirect = r;
    redirectPC = rp; halt = h; imemDone = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0;
    redirectPC = 16'h0; halt = 1'b0; imemDone = 1'b0;
    #1;
    chk("rst.rd", {15'b0, imemRd}, 16'd0);
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic chk_slot(input string nm, input logic ev,
                          input logic [15:0] ei, ep);
    chk({nm, ".valid"}, {15'b0, valid}, {15'b0, ev});
    if (ev) begin
      chk({nm, ".instr"}, instr, ei);
      chk({nm, ".pc2"}, PCplus2, ep);
    end else begin
      chk({nm, ".instr"}, instr, NOP);
    end
  endtask

  task automatic chk_req(input string nm, input logic erd,
                         input logic [15:0] ea);
    chk({nm, ".rd"}, {15'b0, imemRd}, {15'b0, erd});
    if (erd) chk({nm, ".addr"}, imemAddr, ea);
  endtask

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0000, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0002, 1,mem(16'h0000),16'h0002, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0004, 1,mem(16'h0002),16'h0004, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0006, 1,mem(16'h0004),16'h0006, 0));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,1,16'h0008, 1,mem(16'h0006),16'h0008, 0));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,1,16'h0008, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,1,16'h0008, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0008, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,1,16'h000A, 1,mem(16'h0008),16'h000A, 0));
    vecs.push_back(mk(1,0,0,1,16'h0, 1,1,16'h000A, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(1,0,0,1,16'h0, 1,0,16'h0, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,0,16'h0, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h000C, 1,mem(16'h000A),16'h000C, 0));
    vecs.push_back(mk(1,0,0,1,16'h0, 1,0,16'h0, 1,mem(16'h000C),16'h000E, 0));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,1,16'h000E, 1,mem(16'h000C),16'h000E, 0));
    vecs.push_back(mk(0,1,0,0,16'h0040, 1,1,16'h000E, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,0,16'h0, 1,1,16'h000E, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h000E, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0040, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,1,0,1,16'h0031, 0,0,16'h0, 1,mem(16'h0040),16'h0042, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0030, 0,16'h0,16'h0, 1));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,1,16'h0032, 1,mem(16'h0030),16'h0032, 0));
    vecs.push_back(mk(0,0,1,1,16'h0, 1,0,16'h0, 1,mem(16'h0032),16'h0034, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,0,16'h0, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,1,0,1,16'h0100, 1,0,16'h0, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,0,16'h0, 0,16'h0,16'h0, 0));
    vecs.push_back(mk(0,0,0,1,16'h0, 1,0,16'h0, 0,16'h0,16'h0, 0));

    // Directed table straight out of reset.
    do_reset();
    @(negedge clk);
    #1;
    chk("rst.pc2", PCplus2, 16'h0000);
    chk("rst.err", {15'b0, err}, 16'd0);
    chk_slot("rst", 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cyc(vecs[i].s, vecs[i].r, vecs[i].rp, vecs[i].h, vecs[i].d);
      if (vecs[i].ck_rd) chk_req(nm, vecs[i].e_rd, vecs[i].e_addr);
      chk_slot(nm, vecs[i].e_v, vecs[i].e_i, vecs[i].e_p);
      chk({nm, ".err"}, {15'b0, err}, {15'b0, vecs[i].e_err});
    end

    // Halt while waiting: drain old request, then halted for good.
    do_reset();
    cyc(0,0,16'h0,0,0); chk_req("hw0", 1'b1, 16'h0000);
    cyc(0,0,16'h0,1,0); chk_req("hw1", 1'b1, 16'h0000);
    cyc(0,0,16'h0,0,0); chk_req("hw2", 1'b1, 16'h0000);
    chk_slot("hw2", 1'b0, 16'h0, 16'h0);
    cyc(0,0,16'h0,0,1); chk_req("hw3", 1'b1, 16'h0000);
    cyc(0,0,16'h0,0,1); chk_req("hw4", 1'b0, 16'h0);
    chk_slot("hw4", 1'b0, 16'h0, 16'h0);
    cyc(0,1,16'h0080,0,1); chk_req("hw5", 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,16'h0,0,1);
      chk_req("hw6", 1'b0, 16'h0);
      chk_slot("hw6", 1'b0, 16'h0, 16'h0);
    end

    // Redirect beats halt in the same cycle.
    do_reset();
    cyc(0,1,16'h0200,1,1);
    cyc(0,0,16'h0,0,1); chk_req("rh0", 1'b1, 16'h0200);
    cyc(0,0,16'h0,0,1); chk_req("rh1", 1'b1, 16'h0202);
    chk_slot("rh1", 1'b1, mem(16'h0200), 16'h0202);

    // PC and PCplus2 wrap at the top of the address space.
    do_reset();
    cyc(0,1,16'hFFFC,0,1);
    cyc(0,0,16'h0,0,1); chk_req("wr0", 1'b1, 16'hFFFC);
    cyc(0,0,16'h0,0,1); chk_req("wr1", 1'b1, 16'hFFFE);
    chk_slot("wr1", 1'b1, mem(16'hFFFC), 16'hFFFE);
    cyc(0,0,16'h0,0,1); chk_req("wr2", 1'b1, 16'h0000);
    chk_slot("wr2", 1'b1, mem(16'hFFFE), 16'h0000);
    cyc(0,0,16'h0,0,1); chk_req("wr3", 1'b1, 16'h0002);
    chk_slot("wr3", 1'b1, mem(16'h0000), 16'h0002);

    // Reset in the middle of an outstanding request.
    do_reset();
    cyc(0,1,16'h0300,0,1);
    cyc(0,0,16'h0,0,0);
    do_reset();
    cyc(0,0,16'h0,0,1); chk_req("mr0", 1'b1, 16'h0000);
    chk_slot("mr0", 1'b0, 16'h0, 16'h0);
    chk("mr0.pc2", PCplus2, 16'h0000);

    // Random run: decoded stream must follow the architectural PC.
    begin
      logic [15:0] exp_pc;
      logic        exp_err;
      logic        pend;
      logic [15:0] paddr;
      int          consumed;
      do_reset();
      exp_pc = 16'h0000; exp_err = 1'b0; pend = 1'b0;
      paddr = 16'h0; consumed = 0;
      for (int n = 0; n < 3000; n++) begin
        logic s, r, d;
        logic [15:0] rp;
        s = ($urandom_range(0, 3) == 0);
        d = ($urandom_range(0, 2) != 0);
        r = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 2) == 0)
          rp = 16'hFFF8 + 16'($urandom_range(0, 7));
        else
          rp = 16'($urandom());
        cyc(s, r, rp, 1'b0, d);
        chk("rnd.err", {15'b0, err}, {15'b0, exp_err});
        if (pend) begin
          chk("rnd.hold_rd", {15'b0, imemRd}, 16'd1);
          chk("rnd.hold_addr", imemAddr, paddr);
        end
        if (r) begin
          exp_pc = {rp[15:1], 1'b0};
        end else if (valid && !s) begin
          chk("rnd.instr", instr, mem(exp_pc));
          chk("rnd.pc2", PCplus2, exp_pc + 16'd2);
          exp_pc = exp_pc + 16'd2;
          consumed++;
        end
        exp_err = r & rp[0];
        pend = imemRd && !d;
        paddr = imemAddr;
      end
      chk("rnd.progress", {15'b0, consumed >= 500}, 16'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
